// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, drives the combinational
// instruction ROM and holds one fetched word in a registered IF/ID slot with a
// valid/ready handshake toward decode. Branch redirects flush the slot. An illegal
// PC (misaligned or out of range) halts fetch in FAULT until the next redirect.
// Optional feature macro: FETCH_PERF_EN builds the fetch/stall performance counters.
// When it is undefined, both counter outputs are tied to zero.
module fetch_ctrl #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    output logic        fault,
    output logic [63:0] fault_pc,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [63:0] id_pc_q, id_pc_d;
    logic [63:0] fault_pc_q, fault_pc_d;

    logic        slot_free;
    logic        pc_legal;
    logic [64:0] pc_last_byte;

    assign slot_free    = !id_valid_q || id_ready;
    // The last byte is computed in 65 bits so that a PC near 2^64 cannot wrap around and appear to be in range.
    assign pc_last_byte = {1'b0, pc_q} + 65'd3;
    assign pc_legal     = (pc_q[1:0] == 2'b00) && (pc_last_byte < 65'(MEM_BYTES));

    // Next-state logic: redirect has top priority, then fetch/fault in RUN; FAULT only waits.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        fault_pc_d = fault_pc_q;

        if (redirect_valid) begin
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            state_d    = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (slot_free) begin
                        if (pc_legal) begin
                            id_instr_d = imem_instr;
                            id_pc_d    = pc_q;
                            id_valid_d = 1'b1;
                            pc_d       = pc_q + 64'd4;
                        end else begin
                            id_valid_d = 1'b0;
                            state_d    = FAULT;
                            fault_pc_d = pc_q;
                        end
                    end
                end
                FAULT: begin
                    id_valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, PC and IF/ID slot registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_instr_q <= 32'd0;
            id_pc_q    <= 64'd0;
            fault_pc_q <= 64'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Performance counters: accepted instructions (not flushed by a redirect) and back-pressured cycles.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (id_valid_q && id_ready && !redirect_valid) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (id_valid_q && !id_ready) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Counter registers; redirect and fault leave them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign fault     = (state_q == FAULT);
    assign fault_pc  = fault_pc_q;

endmodule
